// File: rtl/prot_key_sequencer.sv
// Protection-PAL key sequencer: acquires the bus, walks a programmable series
// of read strobes into the protection window using a 16-entry nibble table,
// and collects the PAL's SDRD response bit of every step into a result word.
module prot_key_sequencer #(
    parameter int ACC_CYC = 2,
    parameter int MAX_LEN = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [3:0]  cfg_data,
    input  logic [4:0]  seq_len,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] result,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        bus_oe,
    output logic        BA13,
    output logic        BA12,
    output logic [3:0]  BA_NIB,
    output logic        BR_W,
    output logic        SSER,
    input  logic        SDRD
);

    typedef enum logic [2:0] {IDLE, REQ, SETUP, STROBE, RECOV, FIN} state_t;

    localparam logic [4:0] LEN_MAX  = 5'(MAX_LEN);
    localparam logic [3:0] CNT_LAST = 4'(ACC_CYC - 1);

    state_t     state_q, state_d;
    logic [3:0] step_q, step_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] len_q, len_d;
    logic       start_acc;
    logic       abort;
    logic       sample;
    logic       in_bus_d;
    logic [3:0] key_tbl [MAX_LEN];

    // Requested lengths beyond the table depth run the whole table.
    function automatic logic [4:0] clamp_len(input logic [4:0] len);
        return (len > LEN_MAX) ? LEN_MAX : len;
    endfunction

    // The window is only ever read, so BA13 never leaves 0.
    assign BA13 = 1'b0;

    // Next-state logic: sequencing, strobe timing and grant-loss abort.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        start_acc = 1'b0;
        abort     = 1'b0;
        sample    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    step_d    = 4'd0;
                    if (seq_len == 5'd0) begin
                        state_d = FIN;
                    end else begin
                        len_d   = clamp_len(seq_len);
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // Grant wobbling before we own the bus is not an abort.
                if (bus_gnt) begin
                    cnt_d   = 4'd0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (!bus_gnt) begin
                    abort   = 1'b1;
                    state_d = FIN;
                end else begin
                    cnt_d   = 4'd0;
                    state_d = STROBE;
                end
            end
            STROBE: begin
                if (!bus_gnt) begin
                    abort   = 1'b1;
                    state_d = FIN;
                end else if (cnt_q == CNT_LAST) begin
                    sample  = 1'b1;
                    state_d = RECOV;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RECOV: begin
                if (!bus_gnt) begin
                    abort   = 1'b1;
                    state_d = FIN;
                end else if (({1'b0, step_q} + 5'd1) < len_q) begin
                    step_d  = step_q + 4'd1;
                    state_d = SETUP;
                end else begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_bus_d = (state_d == SETUP) || (state_d == STROBE) || (state_d == RECOV);

    // State register plus outputs registered from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= 4'd0;
            cnt_q   <= 4'd0;
            len_q   <= 5'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            result  <= 16'd0;
            bus_req <= 1'b0;
            bus_oe  <= 1'b0;
            BA12    <= 1'b0;
            BA_NIB  <= 4'd0;
            BR_W    <= 1'b0;
            SSER    <= 1'b1;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            busy    <= (state_d != IDLE);
            done    <= (state_d == FIN);
            bus_req <= (state_d == REQ) || in_bus_d;
            bus_oe  <= in_bus_d;
            BA12    <= in_bus_d;
            BR_W    <= in_bus_d;
            BA_NIB  <= in_bus_d ? key_tbl[step_d] : 4'd0;
            SSER    <= (state_d != STROBE);
            if (start_acc) begin
                err    <= 1'b0;
                result <= 16'd0;
            end else begin
                if (abort) begin
                    err <= 1'b1;
                end
                if (sample) begin
                    result[step_q] <= SDRD;
                end
            end
        end
    end

    // Key table: writable only while idle and not on the cycle a start is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                key_tbl[i] <= 4'd0;
            end
        end else if (cfg_we && (state_q == IDLE) && !start) begin
            key_tbl[cfg_addr] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_prot_key_sequencer.sv
// Directed bench for prot_key_sequencer: normal walks, zero and clamped
// lengths, delayed grant, grant-loss abort and asynchronous reset mid-strobe.
module tb_prot_key_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = 4'd0;
    logic [3:0]  cfg_data = 4'd0;
    logic [4:0]  seq_len = 5'd0;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [15:0] result;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    logic        bus_oe, BA13, BA12, BR_W, SSER;
    logic [3:0]  BA_NIB;
    logic        SDRD = 1'b0;

    int checks = 0;
    int errors = 0;

    // Strobe monitor state (written only by the monitor, cleared between runs
    // at instants where the monitor is guaranteed not to touch it).
    logic [15:0] pat = 16'd0;
    int          pulses = 0;
    int          low_cyc = 0;
    logic        req_seen = 1'b0;
    logic        sser_prev = 1'b1;
    logic [3:0]  nib_log [16];

    prot_key_sequencer #(.ACC_CYC(2), .MAX_LEN(16)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .seq_len(seq_len), .start(start),
        .busy(busy), .done(done), .err(err), .result(result),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_oe(bus_oe),
        .BA13(BA13), .BA12(BA12), .BA_NIB(BA_NIB), .BR_W(BR_W),
        .SSER(SSER), .SDRD(SDRD)
    );

    always #5 clk = ~clk;

    // PAL model: logs the nibble of each strobe and answers from pat.
    always @(negedge clk) begin
        if (SSER === 1'b0) begin
            if (sser_prev) begin
                if (pulses < 16) begin
                    nib_log[pulses] = BA_NIB;
                    SDRD = pat[pulses];
                end
                pulses = pulses + 1;
            end
            low_cyc = low_cyc + 1;
        end
        sser_prev = SSER;
        if (bus_req === 1'b1) req_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_tbl(input logic [3:0] a, input logic [3:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic start_seq(input logic [4:0] len);
        @(negedge clk);
        pulses = 0; low_cyc = 0; req_seen = 1'b0;
        seq_len = len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_reached", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int cyc;
        int bad;
        int w;

        // Reset values
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_bus", {26'd0, bus_req, bus_oe, BA13, BA12, BR_W, SSER}, 32'h1);
        chk("rst_nib", {28'd0, BA_NIB}, 32'd0);
        rst = 1'b0;

        // Basic walk: table 1,2,3,4, SDRD 1,0,1,1 -> 0xD
        wr_tbl(4'd0, 4'd1); wr_tbl(4'd1, 4'd2); wr_tbl(4'd2, 4'd3); wr_tbl(4'd3, 4'd4);
        bus_gnt = 1'b1;
        pat = 16'b1101;
        start_seq(5'd4);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        wait_done(cyc);
        chk("t1_latency", cyc, 32'd17);
        chk("t1_pulses", pulses, 32'd4);
        chk("t1_low_cycles", low_cyc, 32'd8);
        chk("t1_nibbles", {16'd0, nib_log[0], nib_log[1], nib_log[2], nib_log[3]}, 32'h1234);
        chk("t1_result", {16'd0, result}, 32'h000D);
        chk("t1_err", {31'd0, err}, 32'd0);
        chk("t1_fin_bus", {27'd0, bus_req, bus_oe, BA12, BR_W, SSER}, 32'h1);
        @(negedge clk);
        chk("t1_done_width", {30'd0, done, busy}, 32'd0);
        chk("t1_result_hold", {16'd0, result}, 32'h000D);

        // Zero length: immediate done, no bus request
        start_seq(5'd0);
        wait_done(cyc);
        chk("t2_latency", cyc, 32'd0);
        chk("t2_result", {16'd0, result}, 32'd0);
        @(negedge clk);
        chk("t2_no_req", {31'd0, req_seen}, 32'd0);
        chk("t2_pulses", pulses, 32'd0);

        // Over-long length clamps to 16 steps
        for (int i = 0; i < 16; i++) wr_tbl(4'(i), 4'hA);
        pat = 16'hFFFF;
        start_seq(5'd20);
        wait_done(cyc);
        chk("t3_latency", cyc, 32'd65);
        chk("t3_pulses", pulses, 32'd16);
        chk("t3_result", {16'd0, result}, 32'h0000FFFF);
        bad = 0;
        for (int i = 0; i < 16; i++) if (nib_log[i] !== 4'hA) bad++;
        chk("t3_nibbles_a", bad, 32'd0);

        // Grant delayed by 10 cycles
        @(negedge clk);
        bus_gnt = 1'b0;
        pat = 16'b10;
        start_seq(5'd2);
        repeat (10) @(negedge clk);
        chk("t4_wait_req", {30'd0, bus_req, bus_oe}, 32'h2);
        chk("t4_wait_pulses", pulses, 32'd0);
        bus_gnt = 1'b1;
        wait_done(cyc);
        chk("t4_latency", cyc, 32'd9);
        chk("t4_pulses", pulses, 32'd2);
        chk("t4_result", {16'd0, result}, 32'h0002);

        // Grant lost during step 2's strobe
        pat = 16'hFFFF;
        start_seq(5'd4);
        w = 0;
        while (pulses < 3 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("t5_reached_step2", pulses, 32'd3);
        bus_gnt = 1'b0;
        @(negedge clk);
        chk("t5_sser_high", {31'd0, SSER}, 32'd1);
        chk("t5_err_done", {30'd0, err, done}, 32'h3);
        chk("t5_bus_oe", {31'd0, bus_oe}, 32'd0);
        chk("t5_result", {16'd0, result}, 32'h0003);
        @(negedge clk);
        chk("t5_idle", {30'd0, busy, done}, 32'd0);
        chk("t5_err_sticky", {31'd0, err}, 32'd1);
        bus_gnt = 1'b1;

        // Asynchronous reset mid-strobe clears the table
        start_seq(5'd2);
        chk("t6_err_cleared", {31'd0, err}, 32'd0);
        w = 0;
        while (pulses < 1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("t6_in_strobe", {31'd0, SSER}, 32'd0);
        rst = 1'b1;
        #1;
        chk("t6_async_sser", {31'd0, SSER}, 32'd1);
        chk("t6_async_oe_busy", {30'd0, bus_oe, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        start_seq(5'd1);
        wait_done(cyc);
        chk("t6_latency", cyc, 32'd5);
        chk("t6_nib_cleared", {28'd0, nib_log[0]}, 32'd0);
        chk("t6_result", {16'd0, result}, 32'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
